// File: rtl/miriscv_data_mem.sv
// rtl/miriscv_data_mem.sv - single-port data memory with byte-enabled writes and 1-cycle registered read
// Optional error flag output err_o is compiled in when MIRISCV_DMEM_ERR_EN is defined.
module miriscv_data_mem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o
`ifdef MIRISCV_DMEM_ERR_EN
    ,
    output logic        err_o
`endif
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] word_idx;
    logic          wr_en;

    // Unsigned subtract lets addresses below BASE_ADDR wrap to huge offsets and fall out of range.
    assign offset   = data_addr_i - BASE_ADDR;
    assign in_range = (offset < SPAN);
    assign word_idx = offset[AW+1:2];
    assign wr_en    = data_req_i && data_we_i && in_range;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem_q[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read data holds between reads because the core samples it during its stall cycle.
    always_comb begin
        rdata_d = rdata_q;
        if (data_req_i && !data_we_i) begin
            rdata_d = in_range ? mem_q[word_idx] : 32'h0;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            rdata_q <= 32'h0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign data_rdata_o = rdata_q;

`ifdef MIRISCV_DMEM_ERR_EN
    logic err_q, err_d;
    logic be_legal;

    always_comb begin
        be_legal = 1'b0;
        case (data_be_i)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
            default:                   be_legal = 1'b0;
        endcase
    end

    // Illegal-be writes are still performed above; only the flag reports them.
    always_comb begin
        err_d = data_req_i && (!in_range || (data_we_i && !be_legal));
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

    req_known_a: assert property (@(posedge clk_i) disable iff (!arstn_i) !$isunknown(data_req_i));

endmodule

// File: tb/tb_miriscv_data_mem.sv
// tb/tb_miriscv_data_mem.sv - self-checking bench for miriscv_data_mem (vectors, random vs. reference model)
module tb_miriscv_data_mem;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        arstn;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
`ifdef MIRISCV_DMEM_ERR_EN
    logic        err;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_rdata;
    logic        ref_err;

    typedef struct {
        bit        req;
        bit        we;
        bit [3:0]  be;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit        chk;
        bit [31:0] exp_rdata;
        bit        exp_err;
    } vec_t;

    vec_t tbl[$];

    miriscv_data_mem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0)) dut (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .data_req_i   (data_req),
        .data_we_i    (data_we),
        .data_be_i    (data_be),
        .data_addr_i  (data_addr),
        .data_wdata_i (data_wdata),
        .data_rdata_o (data_rdata)
`ifdef MIRISCV_DMEM_ERR_EN
        ,
        .err_o        (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %08h expected %08h", name, idx, act, exp);
        end
    endtask

    // Reference: memory as an array of words; in range means offset below DEPTH*4 bytes.
    task automatic model(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] off;
        bit inr, legal;
        off   = addr;
        inr   = (off < DEPTH * 4);
        legal = be inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        if (!req) begin
            ref_err = 1'b0;
        end else if (we) begin
            if (inr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[off / 4][8*b +: 8] = wdata[8*b +: 8];
            end
            ref_err = !inr || !legal;
        end else begin
            ref_rdata = inr ? ref_mem[off / 4] : 32'h0;
            ref_err   = !inr;
        end
    endtask

    task automatic apply(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata, input int idx);
        data_req   = req;
        data_we    = we;
        data_be    = be;
        data_addr  = addr;
        data_wdata = wdata;
        @(posedge clk);
        model(req, we, be, addr, wdata);
        #1;
        check("model_rdata", idx, data_rdata, ref_rdata);
`ifdef MIRISCV_DMEM_ERR_EN
        check("model_err", idx, 32'(err), 32'(ref_err));
`endif
    endtask

    initial begin
        arstn      = 1'b0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_be    = 4'h0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        ref_rdata  = 32'h0;
        ref_err    = 1'b0;

        tbl.push_back('{1, 1, 4'hF, 32'h0000_0000, 32'hABCD_0123, 0, 32'h0, 0});
        tbl.push_back('{1, 1, 4'hF, 32'h0000_0020, 32'h0000_0000, 0, 32'h0, 0});
        tbl.push_back('{1, 1, 4'hF, 32'h0000_0004, 32'h1122_3344, 0, 32'h0, 0});
        tbl.push_back('{1, 1, 4'hF, 32'h0000_0008, 32'h5566_7788, 0, 32'h0, 0});
        tbl.push_back('{1, 1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0, 0});
        tbl.push_back('{1, 0, 4'h0, 32'h0000_0010, 32'h0,         1, 32'hDEAD_BEEF, 0});
        tbl.push_back('{0, 0, 4'h0, 32'h0,         32'h0,         1, 32'hDEAD_BEEF, 0});
        tbl.push_back('{0, 0, 4'h0, 32'h0,         32'h0,         1, 32'hDEAD_BEEF, 0});
        tbl.push_back('{0, 0, 4'h0, 32'h0,         32'h0,         1, 32'hDEAD_BEEF, 0});
        tbl.push_back('{1, 1, 4'h4, 32'h0000_0012, 32'h5A5A_5A5A, 1, 32'hDEAD_BEEF, 0});
        tbl.push_back('{1, 0, 4'h0, 32'h0000_0010, 32'h0,         1, 32'hDE5A_BEEF, 0});
        tbl.push_back('{1, 1, 4'h3, 32'h0000_0010, 32'h1234_1234, 1, 32'hDE5A_BEEF, 0});
        tbl.push_back('{1, 0, 4'hF, 32'h0000_0010, 32'h0,         1, 32'hDE5A_1234, 0});
        tbl.push_back('{1, 1, 4'hF, 32'h0000_1000, 32'h1111_1111, 1, 32'hDE5A_1234, 1});
        tbl.push_back('{1, 0, 4'h0, 32'h0000_1000, 32'h0,         1, 32'h0000_0000, 1});
        tbl.push_back('{1, 0, 4'h0, 32'h0000_0000, 32'h0,         1, 32'hABCD_0123, 0});
        tbl.push_back('{1, 1, 4'h0, 32'h0000_0020, 32'hCAFE_F00D, 1, 32'hABCD_0123, 0});
        tbl.push_back('{1, 0, 4'h0, 32'h0000_0020, 32'h0,         1, 32'h0000_0000, 0});
        tbl.push_back('{1, 1, 4'h5, 32'h0000_0020, 32'hCAFE_F00D, 1, 32'h0000_0000, 1});
        tbl.push_back('{1, 0, 4'h0, 32'h0000_0020, 32'h0,         1, 32'h00FE_000D, 0});
        tbl.push_back('{1, 0, 4'h0, 32'h0000_0000, 32'h0,         1, 32'hABCD_0123, 0});
        tbl.push_back('{1, 0, 4'h0, 32'h0000_0004, 32'h0,         1, 32'h1122_3344, 0});
        tbl.push_back('{1, 0, 4'h0, 32'h0000_0008, 32'h0,         1, 32'h5566_7788, 0});
        tbl.push_back('{0, 0, 4'h0, 32'h0,         32'h0,         1, 32'h5566_7788, 0});
        tbl.push_back('{1, 1, 4'hF, 32'h0000_0FFC, 32'h0BAD_F00D, 1, 32'h5566_7788, 0});
        tbl.push_back('{1, 0, 4'h0, 32'h0000_0FFC, 32'h0,         1, 32'h0BAD_F00D, 0});
        tbl.push_back('{1, 0, 4'h0, 32'hFFFF_FFFC, 32'h0,         1, 32'h0000_0000, 1});

        repeat (3) @(posedge clk);
        #1;
        check("reset_rdata", 0, data_rdata, 32'h0);
        @(negedge clk);
        arstn = 1'b1;
        apply(0, 0, 4'h0, 32'h0, 32'h0, 0);
        check("idle_after_reset", 0, data_rdata, 32'h0);

        for (int w = 0; w < DEPTH; w++)
            apply(1, 1, 4'hF, 32'(w * 4), $urandom, w);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].req, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, i);
            if (tbl[i].chk) begin
                check("tbl_rdata", i, data_rdata, tbl[i].exp_rdata);
`ifdef MIRISCV_DMEM_ERR_EN
                check("tbl_err", i, 32'(err), 32'(tbl[i].exp_err));
`endif
            end
        end
        check("word0_kept", 0, ref_mem[0], 32'hABCD_0123);

        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h0000_1000)
                                           : (32'($urandom_range(0, 1100)) * 4 + 32'($urandom_range(0, 3)));
            apply(32'($urandom_range(0, 3)) != 0, 1'($urandom), 4'($urandom), a, $urandom, i);
        end

        apply(1, 1, 4'hF, 32'h0000_0000, 32'hDEAD_BEEF, 0);
        apply(1, 0, 4'h0, 32'h0000_0000, 32'h0, 1);
        check("pre_reset_rdata", 0, data_rdata, 32'hDEAD_BEEF);
        apply(1, 1, 4'h6, 32'h0000_0004, 32'h0077_0000, 2);
        data_req = 1'b0;
        arstn    = 1'b0;
        #2;
        check("async_reset_rdata", 0, data_rdata, 32'h0);
`ifdef MIRISCV_DMEM_ERR_EN
        check("async_reset_err", 0, 32'(err), 32'h0);
`endif
        ref_rdata = 32'h0;
        ref_err   = 1'b0;
        @(negedge clk);
        arstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 4'h0, 32'h0, 32'h0, i);
            check("post_reset_hold", i, data_rdata, 32'h0);
        end
        apply(1, 0, 4'h0, 32'h0000_0004, 32'h0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/miriscv_data_mem.md
Name: miriscv_data_mem

Overview:
- Data-memory responder: the memory-side end of the core's load/store protocol.
- Accepts one request per cycle (req/we/be/addr/wdata) and performs byte-enabled writes.
- Returns a full 32-bit read word one clock after a read request; the LSU does lane extraction and sign extension.
- Sits between the core LSU and the data-address space; synchronous single-port RAM with registered read data.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two, min 4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4-aligned.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- arstn_i  input  1  reset, asynchronous, active-low.
- data_req_i  input  1  1 = access this cycle.
- data_we_i  input  1  1 = write, 0 = read.
- data_be_i  input  4  byte enables; bit i selects wdata[8i+7:8i].
- data_addr_i  input  32  byte address.
- data_wdata_i  input  32  write data, already lane-replicated by the LSU.
- data_rdata_o  output  32  registered read word.

Behaviour:
- Reset: data_rdata_o = 0 (and err_o = 0 when compiled in). Assertion is asynchronous, release is synchronous to clk_i. Array contents are not cleared by reset.
- In range: (data_addr_i - BASE_ADDR) < DEPTH_WORDS*4, unsigned 32-bit subtract, wrap allowed.
- Word index: (data_addr_i - BASE_ADDR)[log2(DEPTH_WORDS)+1:2]. addr[1:0] is ignored for indexing.
- Write (req=1, we=1, in range):
  - At the rising edge, each byte with be[i]=1 is updated; other bytes keep their value.
  - be=0000 is a no-op.
  - data_rdata_o holds its previous value.
- Read (req=1, we=0):
  - At the rising edge, data_rdata_o takes the full addressed word (or 0 if out of range). be is ignored.
  - Latency is exactly 1 cycle, matching the LSU's single-cycle stall.
- No request (req=0): no array change; data_rdata_o holds. The hold is required because the core samples it during the stall cycle.
- Out-of-range write: discarded, no array change.
- Read after write to the same word on consecutive cycles: returns the written data (no bypass needed; the write has committed).
- One port only: simultaneous read+write in one cycle is impossible by protocol.
- Reset mid-access: the in-flight read result is lost (rdata = 0). A write on the same edge as reset assertion is not guaranteed.
- X on data_req_i: assertion failure in simulation.

Optional Feature:
- Macro: MIRISCV_DMEM_ERR_EN.
- Defined: adds output err_o (1 bit), registered, reset 0.
- err_o = 1 for exactly the cycle after an erroneous request, aligned with data_rdata_o timing; otherwise 0. An erroneous request is either:
  - any out-of-range access, or
  - a write whose be is not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111, excluding be=0000.
- An illegal-be write is still performed using the given be.
- Undefined: no err_o port; out-of-range and illegal-be accesses behave identically except for the missing flag.

Test Plan:
1. Reset low with rdata previously non-zero -> data_rdata_o = 0 immediately, without a clock edge; after release with no req, stays 0.
2. Write 32'hDEADBEEF, be=1111, addr=0x10; next cycle read 0x10 -> data_rdata_o = 32'hDEADBEEF one edge after the read req; holds over 3 idle cycles.
3. Over word 0xDEADBEEF at 0x10:
   - Write wdata=32'h5A5A5A5A, be=0100, addr=0x12 -> read 0x10 returns 32'hDE5ABEEF.
   - Then be=0011 with wdata=32'h12341234 -> read returns 32'hDE5A1234.
4. With DEPTH_WORDS=1024, BASE_ADDR=0:
   - Write 32'h11111111 to 0x1000 -> read 0x1000 returns 0, and word 0 still holds its prior value.
   - With MIRISCV_DMEM_ERR_EN: err_o pulses 1 for one cycle after each of the two accesses.
5. Write 32'hCAFEF00D, be=0000, addr=0x20 -> word unchanged, err_o stays 0. Write be=0101 -> bytes 0 and 2 updated, err_o pulses 1.
6. Back-to-back reads 0x0, 0x4, 0x8 on consecutive cycles -> data_rdata_o shows words 0, 1, 2 on the three following edges, no bubbles.
